// File: rtl/button_port.sv
// rtl/button_port.sv - debounced push-button MMIO peripheral with sticky W1C press flags
module button_port #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   we,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   press_any
);

    // Terminal count: an input that has disagreed with the accepted level for
    // this many consecutive edges is accepted on the next one.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] s1_q;
    logic [NUM_BUTTONS-1:0] s2_q;
    logic [NUM_BUTTONS-1:0] stable_q;
    logic [NUM_BUTTONS-1:0] stable_d;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] press_d;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] clr_mask;
    logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];

    // Store data above the implemented buttons has no effect.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NUM_BUTTONS];

    // Two-flop synchroniser bringing the asynchronous button levels into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce next state: count edges of disagreement, any agreement restarts.
    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accepted level and debounce counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Press flag next state: a new press overrides a same-cycle clear.
    always_comb begin
        rise     = stable_d & ~stable_q;
        clr_mask = we ? wdata[NUM_BUTTONS-1:0] : '0;
        press_d  = (press_q & ~clr_mask) | rise;
    end

    // Sticky press flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= '0;
        end else begin
            press_q <= press_d;
        end
    end

    // Status word: accepted levels in byte 0, press flags in byte 1.
    always_comb begin
        rdata                      = '0;
        rdata[NUM_BUTTONS-1:0]     = stable_q;
        rdata[8 +: NUM_BUTTONS]    = press_q;
    end

    assign press_any = |press_q;

endmodule

// File: tb/tb_button_port.sv
// tb/tb_button_port.sv - randomized self-checking bench for button_port
module tb_button_port;

    localparam int NB = 4;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic          we = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          press_any;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: raw samples taken at each edge since reset (newest first).
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_stable = '0;
    logic [NB-1:0] m_press  = '0;

    button_port #(
        .NUM_BUTTONS(NB),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .we(we),
        .wdata(wdata),
        .rdata(rdata),
        .press_any(press_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Raw sample taken j edges ago; before any sample the synchroniser holds 0.
    function automatic logic [NB-1:0] sample_ago(input int j);
        if (j < hist.size()) return hist[j];
        return '0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        return (32'(m_press) << 8) | 32'(m_stable);
    endfunction

    // One clock edge: advance the model from the inputs seen at the edge,
    // then compare every output at the following falling edge.
    task automatic tick();
        logic [NB-1:0] rose;
        logic [NB-1:0] smp;
        bit            all_diff;
        @(posedge clk);
        hist.push_front(btn_raw);
        if (hist.size() > DB + 2) void'(hist.pop_back());
        rose = '0;
        // A level is accepted once the value reaching the debouncer (raw
        // delayed two edges) has differed from the accepted level on DB
        // consecutive edges ending at this one.
        for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) begin
                smp = sample_ago(j);
                if (j >= hist.size() + 2 && m_stable[i] == 1'b0) all_diff = 1'b0;
                if (smp[i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                if (!m_stable[i]) rose[i] = 1'b1;
                m_stable[i] = ~m_stable[i];
            end
        end
        if (we) m_press = m_press & ~wdata[NB-1:0];
        m_press = m_press | rose;
        @(negedge clk);
        check("rdata", rdata, exp_rdata());
        check("press_any", 32'(press_any), 32'(|m_press));
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_press_any", 32'(press_any), 32'h0);
        m_stable = '0;
        m_press  = '0;
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Held buttons get accepted, then an async reset wipes everything.
        btn_raw = 4'hF;
        repeat (8) tick();
        check("all_held", rdata, 32'h0000_0F0F);
        do_reset();
        btn_raw = '0;
        do_reset();

        // Clean press on button 0.
        btn_raw = 4'h1;
        repeat (5) tick();
        check("clean_before", rdata, 32'h0);
        tick();
        check("clean_after", rdata, 32'h0000_0101);
        check("clean_any", 32'(press_any), 32'h1);

        // Bounce on button 1 is rejected; final rise accepted 6 edges later.
        btn_raw = '0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            btn_raw[1] = ((c % 4) < 2);
            tick();
        end
        check("bounce_none", rdata, 32'h0);
        btn_raw[1] = 1'b1;
        repeat (5) tick();
        check("bounce_before", rdata, 32'h0);
        tick();
        check("bounce_after", rdata, 32'h0000_0202);

        // W1C clear of press 0 only; release of button 1 keeps its flag.
        btn_raw = '0;
        do_reset();
        btn_raw = 4'h3;
        repeat (6) tick();
        check("w1c_pre", rdata, 32'h0000_0303);
        we = 1'b1;
        wdata = 32'h0000_0001;
        tick();
        we = 1'b0;
        wdata = '0;
        check("w1c_clear", rdata, 32'h0000_0203);
        btn_raw = 4'h1;
        repeat (8) tick();
        check("w1c_release", rdata, 32'h0000_0201);

        // Clear held on button 2 while it is accepted: the set wins.
        btn_raw = '0;
        do_reset();
        btn_raw = 4'h4;
        we = 1'b1;
        wdata = 32'h0000_0004;
        repeat (6) tick();
        we = 1'b0;
        wdata = '0;
        check("collide", rdata, 32'h0000_0404);
        tick();
        check("collide_hold", rdata, 32'h0000_0404);

        // Reset mid-count on button 3: re-accepted from scratch.
        btn_raw = '0;
        do_reset();
        btn_raw = 4'h8;
        repeat (4) tick();
        do_reset();
        repeat (5) tick();
        check("midreset_before", rdata, 32'h0);
        tick();
        check("midreset_after", rdata, 32'h0000_0808);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(7) == 0) btn_raw[i] = ~btn_raw[i];
            end
            we    = ($urandom_range(4) == 0);
            wdata = $urandom;
            if ($urandom_range(499) == 0) do_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
